swipt_pll_seq: RTL and testbench

Startup and lock sequencer for the SWIPT receive PLL. It waits for `swipt_alive`, holds the PLL in frequency-load, then releases it into acquisition with the ADC comparator as PLL input. It switches to closed-loop tracking (PLL fed from its own error bit) once lock is confirmed, and returns to acquisition on loss of lock. It sits between the heartbeat detector, the ADC comparator and the PLL, and replaces ad-hoc `load_freq`/`pll_in` glue with one registered FSM.

---
 rtl/swipt_pll_seq_pkg.sv | 24 ++
 rtl/swipt_pll_seq_if.sv | 23 ++
 rtl/swipt_pll_seq_run_counter.sv | 25 ++
 rtl/swipt_pll_seq.sv | 115 +++++++++++
 tb/tb_swipt_pll_seq.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/swipt_pll_seq_pkg.sv
// Shared types and constants for the SWIPT receive-PLL startup/lock sequencer.
package swipt_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ACQ   = 3'd2,
    S_TRACK = 3'd3,
    S_FAULT = 3'd4
  } seq_state_t;

  localparam logic [31:0] DEF_STEP = 32'h32;
  localparam logic [4:0]  LG_ACQ   = 5'd11;
  localparam logic [4:0]  LG_TRK   = 5'd13;

  localparam int ERR_SIGN = 0;
  localparam int ERR_OUT  = 1;

  // States in which the PLL frequency register is held in load.
  function automatic logic holds_load(seq_state_t s);
    return (s == S_IDLE) || (s == S_LOAD) || (s == S_FAULT);
  endfunction

endpackage

// File: rtl/swipt_pll_seq_if.sv
// Signal bundle between the sequencer and its environment (heartbeat, ADC, PLL).
interface swipt_pll_seq_if;
  logic        swipt_alive;
  logic        adc_comp;
  logic [1:0]  pll_err;
  logic        load_freq;
  logic [31:0] freq_step;
  logic [4:0]  lgcoef;
  logic        pll_in;
  logic        locked;
  logic        fault;
  logic [2:0]  state;

  modport master (
    output swipt_alive, adc_comp, pll_err,
    input  load_freq, freq_step, lgcoef, pll_in, locked, fault, state
  );

  modport slave (
    input  swipt_alive, adc_comp, pll_err,
    output load_freq, freq_step, lgcoef, pll_in, locked, fault, state
  );
endinterface

// File: rtl/swipt_pll_seq_run_counter.sv
// Saturating counter of consecutive qualifying cycles; any non-qualifying cycle restarts it.
module run_counter #(
  parameter int LIMIT = 16,
  parameter int W     = $clog2(LIMIT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         term
);

  localparam logic [W-1:0] CNT_MAX = W'(LIMIT - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (clr || !inc)    cnt <= '0;
    else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
  end

  // Terminal: this cycle is the LIMIT-th consecutive qualifying one.
  assign term = inc && (cnt == CNT_MAX);

endmodule

// File: rtl/swipt_pll_seq.sv
// Startup/lock sequencer: IDLE -> LOAD -> ACQ (ADC-fed) <-> TRACK (error-fed), FAULT on timeout.
module swipt_pll_seq
  import swipt_pkg::*;
#(
  parameter int LOAD_CYC  = 4,
  parameter int LOCK_CNT  = 1024,
  parameter int LOSS_CNT  = 16,
  parameter int ACQ_TMO   = 65535,
  parameter int RETRY_CYC = 256
) (
  input logic          clk,
  input logic          rst,
  swipt_pll_seq_if.slave bus
);

  localparam int CYC_LIM = (RETRY_CYC > LOAD_CYC) ? RETRY_CYC : LOAD_CYC;
  localparam int CYC_W   = $clog2(CYC_LIM);
  localparam logic [CYC_W-1:0] LOAD_LAST  = CYC_W'(LOAD_CYC - 1);
  localparam logic [CYC_W-1:0] RETRY_LAST = CYC_W'(RETRY_CYC - 1);
  localparam logic [CYC_W-1:0] CYC_MAX    = CYC_W'(CYC_LIM - 1);
  localparam logic [15:0]      TMO_LAST   = 16'(ACQ_TMO);

  seq_state_t       state_q, state_d;
  logic [15:0]      tmo_cnt;
  logic [CYC_W-1:0] cyc_cnt;
  logic             entering;
  logic             err_out, err_sign;
  logic             ok_term, bad_term;
  logic             load_freq_q, load_freq_d;
  logic [4:0]       lgcoef_q, lgcoef_d;
  logic             locked_q, locked_d;
  logic             fault_q, fault_d;
  logic             pll_in_q, pll_in_d;

  assign err_out  = bus.pll_err[ERR_OUT];
  assign err_sign = bus.pll_err[ERR_SIGN];
  assign entering = (state_d != state_q);

  run_counter #(.LIMIT(LOCK_CNT)) u_ok (
    .clk(clk), .rst(rst),
    .clr((state_q != S_ACQ) || entering),
    .inc(!err_out),
    .cnt(), .term(ok_term)
  );

  run_counter #(.LIMIT(LOSS_CNT)) u_bad (
    .clk(clk), .rst(rst),
    .clr((state_q != S_TRACK) || entering),
    .inc(err_out),
    .cnt(), .term(bad_term)
  );

  // State, dwell counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tmo_cnt     <= '0;
      cyc_cnt     <= '0;
      load_freq_q <= 1'b1;
      lgcoef_q    <= LG_ACQ;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
      pll_in_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_freq_q <= load_freq_d;
      lgcoef_q    <= lgcoef_d;
      locked_q    <= locked_d;
      fault_q     <= fault_d;
      pll_in_q    <= pll_in_d;
      if (entering || (state_q != S_ACQ))  tmo_cnt <= '0;
      else if (tmo_cnt != TMO_LAST)        tmo_cnt <= tmo_cnt + 1'b1;
      if (entering || !((state_q == S_LOAD) || (state_q == S_FAULT))) cyc_cnt <= '0;
      else if (cyc_cnt != CYC_MAX)         cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

  // Next state; losing the heartbeat overrides everything
  always_comb begin
    state_d = state_q;
    if (!bus.swipt_alive) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_LOAD;
        S_LOAD:  if (cyc_cnt == LOAD_LAST) state_d = S_ACQ;
        S_ACQ: begin
          if (ok_term)                   state_d = S_TRACK;
          else if (tmo_cnt == TMO_LAST)  state_d = S_FAULT;
        end
        S_TRACK: if (bad_term) state_d = S_ACQ;
        S_FAULT: if (cyc_cnt == RETRY_LAST) state_d = S_LOAD;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from the next state so they line up with the state register
  always_comb begin
    load_freq_d = holds_load(state_d);
    lgcoef_d    = (state_d == S_TRACK) ? LG_TRK : LG_ACQ;
    locked_d    = (state_d == S_TRACK);
    fault_d     = (state_d == S_FAULT);
    pll_in_d    = (state_q == S_TRACK) ? err_sign : bus.adc_comp;
  end

  assign bus.state     = state_q;
  assign bus.load_freq = load_freq_q;
  assign bus.freq_step = DEF_STEP;
  assign bus.lgcoef    = lgcoef_q;
  assign bus.locked    = locked_q;
  assign bus.fault     = fault_q;
  assign bus.pll_in    = pll_in_q;

endmodule

// File: tb/tb_swipt_pll_seq.sv
// Directed bench for swipt_pll_seq: startup table, lock/glitch/loss, timeout/retry, alive drop, reset, lock-vs-timeout.
module tb_swipt_pll_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  swipt_pll_seq_if bus ();
  swipt_pll_seq_if bus2 ();

  swipt_pll_seq dut (.clk(clk), .rst(rst), .bus(bus));

  swipt_pll_seq #(
    .LOAD_CYC(2), .LOCK_CNT(4), .LOSS_CNT(2), .ACQ_TMO(11), .RETRY_CYC(4)
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    logic       alive;
    logic       adc;
    logic [1:0] err;
    logic [2:0] st;
    logic       ld;
    logic       pin;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_st(input string nm, input logic [2:0] st, input logic ld,
                        input logic [4:0] lg, input logic lk, input logic ft);
    chk({nm, ".state"},     32'(bus.state),     32'(st));
    chk({nm, ".load_freq"}, 32'(bus.load_freq), 32'(ld));
    chk({nm, ".lgcoef"},    32'(bus.lgcoef),    32'(lg));
    chk({nm, ".locked"},    32'(bus.locked),    32'(lk));
    chk({nm, ".fault"},     32'(bus.fault),     32'(ft));
  endtask

  task automatic run(input int n, input logic a, input logic c, input logic [1:0] e);
    bus.swipt_alive = a;
    bus.adc_comp    = c;
    bus.pll_err     = e;
    repeat (n) tick();
  endtask

  task automatic run2(input int n, input logic a, input logic [1:0] e);
    bus2.swipt_alive = a;
    bus2.adc_comp    = 1'b0;
    bus2.pll_err     = e;
    repeat (n) tick();
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 2'b10, 3'd0, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 2'b10, 3'd1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 2'b10, 3'd1, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 2'b10, 3'd1, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 2'b10, 3'd1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 2'b10, 3'd2, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 2'b10, 3'd2, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 2'b10, 3'd2, 1'b0, 1'b1};

    bus.swipt_alive = 1'b0; bus.adc_comp = 1'b1; bus.pll_err = 2'b10;
    bus2.swipt_alive = 1'b0; bus2.adc_comp = 1'b0; bus2.pll_err = 2'b10;

    // Reset values while rst is held across several edges
    repeat (3) tick();
    chk_st("reset", 3'd0, 1'b1, 5'd11, 1'b0, 1'b0);
    chk("reset.pll_in",    32'(bus.pll_in), 32'd0);
    chk("reset.freq_step", bus.freq_step,   32'h32);
    rst = 1'b0;

    // Startup: IDLE, four LOAD cycles, then ACQ; pll_in mirrors adc_comp one cycle late
    for (int i = 0; i < 8; i++) begin
      run(1, vecs[i].alive, vecs[i].adc, vecs[i].err);
      chk($sformatf("startup[%0d].state", i),     32'(bus.state),     32'(vecs[i].st));
      chk($sformatf("startup[%0d].load_freq", i), 32'(bus.load_freq), 32'(vecs[i].ld));
      chk($sformatf("startup[%0d].pll_in", i),    32'(bus.pll_in),    32'(vecs[i].pin));
      chk($sformatf("startup[%0d].lgcoef", i),    32'(bus.lgcoef),    32'd11);
    end

    // Glitch at good-count 1000 restarts the run; lock needs 1024 fresh goods
    run(1000, 1'b1, 1'b0, 2'b00);
    chk_st("pre_glitch", 3'd2, 1'b0, 5'd11, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0, 2'b10);
    run(1023, 1'b1, 1'b0, 2'b00);
    chk_st("glitch_1023", 3'd2, 1'b0, 5'd11, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0, 2'b00);
    chk_st("glitch_lock", 3'd3, 1'b0, 5'd13, 1'b1, 1'b0);

    // Loss of lock: 15 bad + 1 good holds, 16 bad drops back to ACQ without reload
    run(15, 1'b1, 1'b0, 2'b10);
    chk_st("bad15", 3'd3, 1'b0, 5'd13, 1'b1, 1'b0);
    run(1, 1'b1, 1'b0, 2'b00);
    chk_st("bad15_good", 3'd3, 1'b0, 5'd13, 1'b1, 1'b0);
    run(15, 1'b1, 1'b0, 2'b10);
    chk_st("bad_15b", 3'd3, 1'b0, 5'd13, 1'b1, 1'b0);
    run(1, 1'b1, 1'b0, 2'b10);
    chk_st("bad16", 3'd2, 1'b0, 5'd11, 1'b0, 1'b0);

    // Clean lock from re-entered ACQ; pll_in switches to the error sign one cycle after entry
    run(1023, 1'b1, 1'b0, 2'b01);
    chk_st("lock_1023", 3'd2, 1'b0, 5'd11, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0, 2'b01);
    chk_st("lock_1024", 3'd3, 1'b0, 5'd13, 1'b1, 1'b0);
    chk("lock_entry.pll_in", 32'(bus.pll_in), 32'd0);
    run(1, 1'b1, 1'b0, 2'b01);
    chk("track_sign1.pll_in", 32'(bus.pll_in), 32'd1);
    run(1, 1'b1, 1'b1, 2'b00);
    chk("track_sign0.pll_in", 32'(bus.pll_in), 32'd0);

    // Heartbeat lost in TRACK: IDLE on the next cycle
    run(1, 1'b0, 1'b1, 2'b00);
    chk_st("alive_drop", 3'd0, 1'b1, 5'd11, 1'b0, 1'b0);
    run(1, 1'b1, 1'b1, 2'b10);
    chk_st("reload", 3'd1, 1'b1, 5'd11, 1'b0, 1'b0);
    chk("reload.pll_in", 32'(bus.pll_in), 32'd1);

    // Asynchronous reset mid-LOAD takes effect without a clock edge
    #2 rst = 1'b1;
    #1;
    chk_st("async_rst", 3'd0, 1'b1, 5'd11, 1'b0, 1'b0);
    chk("async_rst.pll_in", 32'(bus.pll_in), 32'd0);
    tick();
    rst = 1'b0;

    // Acquisition timeout: 65536 ACQ cycles with error outside window, then FAULT dwell and retry
    run(4, 1'b1, 1'b0, 2'b10);
    chk_st("tmo_load", 3'd1, 1'b1, 5'd11, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0, 2'b10);
    chk_st("tmo_acq", 3'd2, 1'b0, 5'd11, 1'b0, 1'b0);
    run(65535, 1'b1, 1'b0, 2'b10);
    chk_st("tmo_65535", 3'd2, 1'b0, 5'd11, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0, 2'b10);
    chk_st("tmo_fault", 3'd4, 1'b1, 5'd11, 1'b0, 1'b1);
    run(255, 1'b1, 1'b0, 2'b10);
    chk_st("retry_255", 3'd4, 1'b1, 5'd11, 1'b0, 1'b1);
    run(1, 1'b1, 1'b0, 2'b10);
    chk_st("retry_load", 3'd1, 1'b1, 5'd11, 1'b0, 1'b0);

    // Small instance: lock and timeout on the same cycle resolve to TRACK
    run2(3, 1'b1, 2'b10);
    chk("col_acq.state", 32'(bus2.state), 32'd2);
    run2(8, 1'b1, 2'b10);
    run2(3, 1'b1, 2'b00);
    chk("col_pre.state", 32'(bus2.state), 32'd2);
    run2(1, 1'b1, 2'b00);
    chk("col_lock.state", 32'(bus2.state), 32'd3);
    chk("col_lock.locked", 32'(bus2.locked), 32'd1);
    run2(1, 1'b0, 2'b00);
    chk("col_idle.state", 32'(bus2.state), 32'd0);
    run2(3, 1'b1, 2'b10);
    chk("tmo2_acq.state", 32'(bus2.state), 32'd2);
    run2(9, 1'b1, 2'b10);
    run2(2, 1'b1, 2'b00);
    chk("tmo2_pre.state", 32'(bus2.state), 32'd2);
    run2(1, 1'b1, 2'b00);
    chk("tmo2_fault.state", 32'(bus2.state), 32'd4);
    chk("tmo2_fault.fault", 32'(bus2.fault), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
